// File: rtl/clk_period_meter.sv
// ---------------------------------------------------------------------------
// clk_period_meter
//
// Measures a slow periodic input against the system clock. For every pair of
// consecutive rising edges on sig_in it reports the full period and the high
// time (rising edge to falling edge), both in clk cycles. Measurement runs
// back-to-back while enabled. An input that produces no rising edge for
// TIMEOUT_CYC cycles raises a sticky stall flag.
//
// Ports:
//   clk        in   system clock, all logic on its rising edge
//   rst_n      in   synchronous active-low reset
//   enable     in   measurement enable; low forces IDLE
//   sig_in     in   asynchronous slow signal under measurement
//   period     out  last measured period (clk cycles)
//   high_time  out  high time belonging to the same period
//   meas_valid out  one-cycle pulse coincident with updated period/high_time
//   stalled    out  sticky: no rising edge within TIMEOUT_CYC cycles
//   busy       out  high while armed or measuring
// ---------------------------------------------------------------------------
module clk_period_meter #(
    parameter int CNT_W       = 24,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             stalled,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q;
    logic             sync1_q, sync2_q, prev_q;
    logic [2:0]       fill_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] to_q;
    logic [CNT_W-1:0] hi_cap_q;
    logic             hi_seen_q;
    logic [CNT_W-1:0] period_q, high_time_q;
    logic             meas_valid_q, stalled_q;

    logic rise_det, fall_det;

    // Reset clears the synchronizer and edge register, so for three cycles
    // afterwards they hold zeros rather than real samples. fill_q marks when
    // both sync2_q and prev_q carry genuine input samples; without it a signal
    // that is high across reset would look like a fresh rising edge and arm
    // the meter mid-period.
    assign rise_det = fill_q[2] &  sync2_q & ~prev_q;
    assign fall_det = fill_q[2] & ~sync2_q &  prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            fill_q       <= 3'b000;
            cnt_q        <= '0;
            to_q         <= '0;
            hi_cap_q     <= '0;
            hi_seen_q    <= 1'b0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            stalled_q    <= 1'b0;
        end else begin
            sync1_q      <= sig_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            fill_q       <= {fill_q[1:0], 1'b1};
            meas_valid_q <= 1'b0;

            if (!enable) begin
                // Drop any partial measurement; results and stall flag hold.
                state_q   <= IDLE;
                cnt_q     <= '0;
                to_q      <= '0;
                hi_seen_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= ARM;
                        cnt_q   <= '0;
                        to_q    <= '0;
                    end

                    ARM: begin
                        if (rise_det) begin
                            state_q   <= MEASURE;
                            cnt_q     <= ONE;
                            hi_seen_q <= 1'b0;
                            to_q      <= '0;
                        end else if (to_q == TO_LAST) begin
                            stalled_q <= 1'b1;
                            to_q      <= '0;
                        end else begin
                            to_q <= to_q + ONE;
                        end
                    end

                    MEASURE: begin
                        // Rising edge is checked first so it beats a
                        // timeout landing in the same cycle.
                        if (rise_det) begin
                            period_q     <= cnt_q;
                            high_time_q  <= hi_seen_q ? hi_cap_q : cnt_q;
                            meas_valid_q <= 1'b1;
                            stalled_q    <= 1'b0;
                            cnt_q        <= ONE;
                            hi_seen_q    <= 1'b0;
                            to_q         <= '0;
                        end else if (to_q == TO_LAST) begin
                            stalled_q <= 1'b1;
                            state_q   <= ARM;
                            cnt_q     <= '0;
                            to_q      <= '0;
                            hi_seen_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                            to_q  <= to_q + ONE;
                            if (fall_det && !hi_seen_q) begin
                                hi_cap_q  <= cnt_q;
                                hi_seen_q <= 1'b1;
                            end
                        end
                    end

                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign stalled    = stalled_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_clk_period_meter.sv
// ---------------------------------------------------------------------------
// tb_clk_period_meter
//
// Directed bench for clk_period_meter. A small pattern generator drives
// sig_in with a programmable high/low length; the initial block walks
// through the scenarios and checks results against hand-computed values.
// ---------------------------------------------------------------------------
module tb_clk_period_meter;

    localparam int CNT_W = 16;
    localparam int TO    = 100;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             stalled;
    logic             busy;

    int tests = 0;
    int fails = 0;

    // Pattern generator: high for gen_hi cycles, low for gen_lo cycles.
    // When stopped it parks at the last phase so a restart begins with a
    // clean, full-length high phase.
    int gen_hi = 10;
    int gen_lo = 10;
    bit gen_on = 1'b0;
    int ph     = 0;

    clk_period_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .stalled   (stalled),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (gen_on) begin
            if (ph >= gen_hi + gen_lo - 1) ph = 0;
            else                           ph = ph + 1;
            sig_in = (ph < gen_hi);
        end else begin
            ph     = gen_hi + gen_lo - 1;
            sig_in = 1'b0;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int maxc, output int n, output bit got);
        got = 1'b0;
        n   = 0;
        while (!got && n < maxc) begin
            @(negedge clk);
            n++;
            if (meas_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic expect_meas(input string tag, input int p, input int h, output int n);
        bit got;
        wait_valid(200, n, got);
        chk({tag, "_got"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_period"}, 32'(period), 32'(p));
            chk({tag, "_high"}, 32'(high_time), 32'(h));
        end
    endtask

    task automatic discard(input int k);
        int n;
        bit got;
        for (int i = 0; i < k; i++) wait_valid(200, n, got);
    endtask

    initial begin
        int n;
        int mv_cnt;

        // Reset state
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_high", 32'(high_time), 32'd0);
        chk("rst_valid", 32'(meas_valid), 32'd0);
        chk("rst_stalled", 32'(stalled), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: period 20, 50% duty, pulse spacing 20
        gen_hi = 10; gen_lo = 10; gen_on = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("t1_busy", 32'(busy), 32'd1);
        expect_meas("t1_first", 20, 10, n);
        expect_meas("t1_second", 20, 10, n);
        chk("t1_gap", 32'(n), 32'd20);
        expect_meas("t1_third", 20, 10, n);
        chk("t1_gap2", 32'(n), 32'd20);

        // 2: period 7, high 2
        gen_hi = 2; gen_lo = 5;
        discard(2);
        expect_meas("t2_a", 7, 2, n);
        expect_meas("t2_b", 7, 2, n);
        chk("t2_gap", 32'(n), 32'd7);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_stalled", 32'(stalled), 32'd0);

        // 3: input stops low -> stall, then recovers
        gen_hi = 10; gen_lo = 10;
        discard(2);
        expect_meas("t3_pre", 20, 10, n);
        gen_on = 1'b0;
        repeat (60) @(negedge clk);
        chk("t3_not_yet", 32'(stalled), 32'd0);
        n = 0; mv_cnt = 0;
        while (stalled !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (meas_valid === 1'b1) mv_cnt++;
        end
        chk("t3_stalled", 32'(stalled), 32'd1);
        chk("t3_no_valid", 32'(mv_cnt), 32'd0);
        chk("t3_period_hold", 32'(period), 32'd20);
        chk("t3_high_hold", 32'(high_time), 32'd10);
        chk("t3_busy", 32'(busy), 32'd1);
        gen_on = 1'b1;
        expect_meas("t3_resume", 20, 10, n);
        chk("t3_stall_clear", 32'(stalled), 32'd0);

        // 4: one-cycle reset mid-period
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t4_period", 32'(period), 32'd0);
        chk("t4_high", 32'(high_time), 32'd0);
        chk("t4_valid", 32'(meas_valid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_stalled", 32'(stalled), 32'd0);
        expect_meas("t4_after", 20, 10, n);

        // 5: enable low for 5 cycles across the point where a result was due
        repeat (17) @(negedge clk);
        enable = 1'b0;
        mv_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (meas_valid === 1'b1) mv_cnt++;
        end
        chk("t5_no_valid", 32'(mv_cnt), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_period_hold", 32'(period), 32'd20);
        enable = 1'b1;
        expect_meas("t5_rearm", 20, 10, n);

        // 6: long high phase, then narrow low pulse
        gen_hi = 50; gen_lo = 10;
        discard(2);
        expect_meas("t6_long", 60, 50, n);
        gen_hi = 18; gen_lo = 2;
        discard(2);
        expect_meas("t6_narrow", 20, 18, n);
        chk("t6_stalled", 32'(stalled), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Measures a slow periodic input, such as the output of the team's clock divider, against the system clock `clk`.
- Reports two values, in `clk` cycles:
  - full period, rising edge to rising edge;
  - high time, rising edge to falling edge.
- Used on-chip and in benches to check divider ratios and duty cycle without waveform inspection.
- Measures continuously while enabled; flags a stalled input with a timeout.

Parameters:
- CNT_W, 24, width of the period/high-time counter and result registers.
- TIMEOUT_CYC, 1000000, cycles without a rising edge before `stalled` asserts; must be < 2^CNT_W - 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- enable  input  1  measurement enable; low forces IDLE.
- sig_in  input  1  asynchronous slow signal under measurement.
- period  output  CNT_W  last measured period in clk cycles.
- high_time  output  CNT_W  high time of the same period.
- meas_valid  output  1  one-cycle pulse when period/high_time update.
- stalled  output  1  sticky: no rising edge within TIMEOUT_CYC.
- busy  output  1  high in ARM or MEASURE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE;
  - sync FFs, edge register, counter and all outputs = 0;
  - reset mid-measurement discards the partial count.
- Input path:
  - two-FF synchronizer, then one edge register;
  - rise_det = sync & ~prev, fall_det = ~sync & prev;
  - fixed 3-cycle detection latency, identical for both edges, so differences are exact.
- States: IDLE, ARM, MEASURE.
  - IDLE: counter held at 0. enable=1 -> ARM.
  - ARM: waits for the first rise_det. On rise_det: cnt<=1, hi_seen<=0, -> MEASURE. No result is produced from the partial first period.
  - MEASURE: cnt increments by 1 every cycle.
    - On fall_det with hi_seen=0: capture register hi_cap<=cnt, hi_seen<=1.
    - On rise_det:
      - period<=cnt;
      - high_time<=hi_cap if hi_seen, else cnt (no fall seen means the signal was high for the whole period);
      - meas_valid=1 for exactly one cycle, coincident with the updated values;
      - stalled<=0;
      - cnt<=1, hi_seen<=0, stay in MEASURE (back-to-back measurement, no lost period).
- Count definition: for a rising-edge spacing of P clk cycles and high time H, period=P and high_time=H exactly (steady input, no jitter).
- Timeout:
  - in ARM or MEASURE, an idle counter runs while waiting for rise_det;
  - if it reaches TIMEOUT_CYC: stalled<=1 (sticky), state -> ARM, cnt cleared;
  - period/high_time keep their last values;
  - stalled clears only on the next completed measurement or on reset.
- enable deassert:
  - the next cycle is IDLE and any partial measurement is dropped;
  - meas_valid=0; period/high_time/stalled hold.
  - Re-enable re-arms, so the first result arrives after one full period plus the arm edge.
- Simultaneous rise_det and timeout in the same cycle: the rising edge wins (measurement completes, no stall).
- Minimum resolvable input: high and low phases each >= 2 clk cycles. Narrower pulses may be missed; this is not required to be flagged.
- The counter never wraps: timeout fires before CNT_W overflow.
- busy = (state != IDLE).
- meas_valid is never asserted in IDLE or ARM.

Test Plan:
1. clk_div output with period 20 cycles, 50% duty, enable=1 -> first meas_valid after the arm edge plus one period; period=20, high_time=10. Every subsequent period repeats with a 20-cycle pulse spacing.
2. Input period 7 cycles, high 2 -> period=7, high_time=2 on every meas_valid. busy=1 throughout, stalled=0.
3. Input stops low after 3 periods of 20 (TIMEOUT_CYC=100 in bench):
   - stalled=1 after 100 cycles without a rising edge;
   - period stays 20;
   - restart the input -> stalled=0 at the next meas_valid.
4. rst_n=0 for one cycle mid-period -> next cycle all outputs 0 and state IDLE. With enable still 1, the first valid result is a full correct period (20), never a partial count.
5. enable dropped for 5 cycles mid-measurement, then raised:
   - no meas_valid while low;
   - period holds its old value;
   - after re-arm, the reported value is correct (20/10).
6. Input constant high for 50 cycles between two rising edges 60 cycles apart (one 10-cycle low) -> period=60, high_time=50. A follow-up case with a 2-cycle low pulse gives period=P, high_time=P-2.
